// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control: Moore sequencer with registered control word and ALU decoder.
// Reset masks every write enable and presents FETCH controls while it is high.
module mips_multicycle_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic [2:0] ALUControl,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       PCEn,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef struct packed {
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       pcwrite;
    logic       branch;
    logic [1:0] aluop;
  } ctrl_t;

  function automatic state_t next_of(input state_t s, input logic [5:0] op);
    state_t n;
    n = FETCH;
    case (s)
      FETCH:   n = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: n = MEMADR;
          OP_RTYPE:     n = EXECUTE;
          OP_BEQ:       n = BRANCH;
          OP_ADDI:      n = ADDIEX;
          OP_J:         n = JUMP;
          default:      n = FETCH;
        endcase
      end
      MEMADR:  n = (op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   n = MEMWB;
      EXECUTE: n = ALUWB;
      ADDIEX:  n = ADDIWB;
      default: n = FETCH;
    endcase
    return n;
  endfunction

  function automatic ctrl_t decode(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.alusrcb = 2'b01;
        c.irwrite = 1'b1;
        c.pcwrite = 1'b1;
      end
      DECODE:  c.alusrcb = 2'b11;
      MEMADR, ADDIEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      MEMRD:   c.iord = 1'b1;
      MEMWB: begin
        c.memtoreg = 1'b1;
        c.regwrite = 1'b1;
      end
      MEMWR: begin
        c.iord     = 1'b1;
        c.memwrite = 1'b1;
      end
      EXECUTE: begin
        c.alusrca = 1'b1;
        c.aluop   = 2'b10;
      end
      ALUWB: begin
        c.regdst   = 1'b1;
        c.regwrite = 1'b1;
      end
      ADDIWB:  c.regwrite = 1'b1;
      BRANCH: begin
        c.alusrca = 1'b1;
        c.aluop   = 2'b01;
        c.pcsrc   = 2'b01;
        c.branch  = 1'b1;
      end
      JUMP: begin
        c.pcsrc   = 2'b10;
        c.pcwrite = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  state_t state;
  state_t state_nxt;
  ctrl_t  ctrl_q;
  ctrl_t  ctrl_o;

  always_comb begin
    state_nxt = reset ? FETCH : next_of(state, Op);
  end

  // Control word is decoded from the next state so it lines up with the state register.
  always_ff @(posedge clk) begin
    state  <= state_nxt;
    ctrl_q <= decode(state_nxt);
  end

  always_comb begin
    ctrl_o = ctrl_q;
    if (reset) begin
      ctrl_o         = decode(FETCH);
      ctrl_o.irwrite = 1'b0;
      ctrl_o.pcwrite = 1'b0;
    end
  end

  always_comb begin
    ALUControl = 3'b010;
    case (ctrl_o.aluop)
      2'b01: ALUControl = 3'b110;
      2'b10: begin
        case (Funct)
          6'b100010: ALUControl = 3'b110;
          6'b100100: ALUControl = 3'b000;
          6'b100101: ALUControl = 3'b001;
          6'b101010: ALUControl = 3'b111;
          default:   ALUControl = 3'b010;
        endcase
      end
      default: ALUControl = 3'b010;
    endcase
  end

  assign ALUSrcA  = ctrl_o.alusrca;
  assign ALUSrcB  = ctrl_o.alusrcb;
  assign PCSrc    = ctrl_o.pcsrc;
  assign IorD     = ctrl_o.iord;
  assign MemWrite = ctrl_o.memwrite;
  assign IRWrite  = ctrl_o.irwrite;
  assign RegWrite = ctrl_o.regwrite;
  assign RegDst   = ctrl_o.regdst;
  assign MemtoReg = ctrl_o.memtoreg;
  assign PCEn     = ctrl_o.pcwrite | (ctrl_o.branch & Zero);
  assign State    = reset ? 4'd0 : state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: instruction-path model with per-cycle compare,
// directed literal checks, then randomized instruction/reset/Zero traffic.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] Op = 6'd0;
  logic [5:0] Funct = 6'd0;
  logic       Zero = 1'b0;
  logic [2:0] ALUControl;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] PCSrc;
  logic       IorD, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg, PCEn;
  logic [3:0] State;

  mips_multicycle_ctrl dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Zero(Zero),
    .ALUControl(ALUControl), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc),
    .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .PCEn(PCEn), .State(State)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int exp_state = 0;
  int pend[$];
  bit model_valid = 1'b0;

  // Model: an instruction is FETCH, DECODE, then an opcode-specific list of steps.
  always @(posedge clk) begin
    if (reset) begin
      exp_state = 0;
      pend.delete();
      model_valid = 1'b1;
    end else if (model_valid) begin
      if (exp_state == 1) begin
        case (Op)
          6'b100011: pend = '{2, 3, 4};
          6'b101011: pend = '{2, 5};
          6'b000000: pend = '{6, 7};
          6'b000100: pend = '{8};
          6'b001000: pend = '{9, 10};
          6'b000010: pend = '{11};
          default:   pend.delete();
        endcase
      end
      if (pend.size() > 0) exp_state = pend.pop_front();
      else exp_state = (exp_state == 0) ? 1 : 0;
    end
  end

  function automatic logic [18:0] exp_out(input int s, input bit rst, input bit z,
                                          input logic [5:0] f);
    int st;
    int aluop;
    logic srca, iord, memw, irw, regw, regdst, m2r, pcw, br;
    logic [1:0] srcb, pcsrc;
    logic [2:0] aluc;
    st = rst ? 0 : s;
    aluop = 0;
    {srca, iord, memw, irw, regw, regdst, m2r, pcw, br} = '0;
    srcb = 2'b00;
    pcsrc = 2'b00;
    case (st)
      0:  begin srcb = 2'b01; irw = 1; pcw = 1; end
      1:  srcb = 2'b11;
      2, 9: begin srca = 1; srcb = 2'b10; end
      3:  iord = 1;
      4:  begin m2r = 1; regw = 1; end
      5:  begin iord = 1; memw = 1; end
      6:  begin srca = 1; aluop = 2; end
      7:  begin regdst = 1; regw = 1; end
      8:  begin srca = 1; aluop = 1; pcsrc = 2'b01; br = 1; end
      10: regw = 1;
      11: begin pcsrc = 2'b10; pcw = 1; end
      default: ;
    endcase
    if (rst) begin irw = 0; pcw = 0; end
    if (aluop == 0) aluc = 3'b010;
    else if (aluop == 1) aluc = 3'b110;
    else begin
      case (f)
        6'b100000: aluc = 3'b010;
        6'b100010: aluc = 3'b110;
        6'b100100: aluc = 3'b000;
        6'b100101: aluc = 3'b001;
        6'b101010: aluc = 3'b111;
        default:   aluc = 3'b010;
      endcase
    end
    return {st[3:0], aluc, srca, srcb, pcsrc, iord, memw, irw, regw, regdst, m2r,
            pcw | (br & z)};
  endfunction

  logic [18:0] got_w, exp_w;
  always @(negedge clk) begin
    if (model_valid) begin
      got_w = {State, ALUControl, ALUSrcA, ALUSrcB, PCSrc, IorD, MemWrite, IRWrite,
               RegWrite, RegDst, MemtoReg, PCEn};
      exp_w = exp_out(exp_state, reset, Zero, Funct);
      total++;
      if (got_w !== exp_w) begin
        bad++;
        $display("FAIL cycle_outputs t=%0t got=%05h expected=%05h", $time, got_w, exp_w);
      end
    end
  end

  task automatic lit(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d", name, act, expv);
    end
  endtask

  int cap_seq;
  logic [15:0] cap_regw, cap_memw, cap_pcen, cap_irw, cap_regdst, cap_m2r;
  int cap_aluc[16];
  int cap_pcsrc[16];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1 while in FETCH; captures n cycles of outputs.
  task automatic run(input logic [5:0] op, input logic [5:0] f, input logic z, input int n);
    Op = op; Funct = f; Zero = z;
    cap_seq = 0;
    {cap_regw, cap_memw, cap_pcen, cap_irw, cap_regdst, cap_m2r} = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cap_seq = cap_seq * 16 + int'(State);
      cap_regw[i] = RegWrite; cap_memw[i] = MemWrite; cap_pcen[i] = PCEn;
      cap_irw[i] = IRWrite; cap_regdst[i] = RegDst; cap_m2r[i] = MemtoReg;
      cap_aluc[i] = int'(ALUControl); cap_pcsrc[i] = int'(PCSrc);
      step();
    end
  endtask

  logic [5:0] op_tab[7] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                            6'b001000, 6'b000010, 6'b111111};
  logic [5:0] fn_tab[6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                            6'b101010, 6'b011011};
  logic [2:0] fn_code[4] = '{3'b110, 3'b000, 3'b001, 3'b111};

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      lit("rst_state", int'(State), 0);
      lit("rst_write_en", int'({MemWrite, IRWrite, RegWrite, PCEn}), 0);
      lit("rst_aluc", int'(ALUControl), 2);
    end
    step();
    reset = 1'b0;

    run(6'b100011, 6'd0, 1'b0, 5);
    lit("lw_seq", cap_seq, 'h01234);
    lit("first_irwrite", int'(cap_irw[0]), 1);
    lit("first_pcen", int'(cap_pcen[0]), 1);
    lit("first_aluc", cap_aluc[0], 2);
    lit("lw_regwrite", int'(cap_regw[4:0]), 'b10000);
    lit("lw_memtoreg", int'(cap_m2r[4]), 1);
    lit("lw_regdst", int'(cap_regdst[4]), 0);

    run(6'b000000, 6'b100010, 1'b0, 4);
    lit("sub_seq", cap_seq, 'h0167);
    lit("sub_aluc", cap_aluc[2], 6);
    lit("sub_regwrite", int'(cap_regw[3:0]), 'b1000);
    lit("sub_regdst", int'(cap_regdst[3]), 1);
    for (int k = 0; k < 4; k++) begin
      run(6'b000000, fn_tab[k + 1], 1'b0, 4);
      lit("rtype_aluc", cap_aluc[2], int'(fn_code[k]));
    end

    run(6'b000100, 6'd0, 1'b1, 3);
    lit("beq_seq", cap_seq, 'h018);
    lit("beq_taken_pcen", int'(cap_pcen[2]), 1);
    lit("beq_pcsrc", cap_pcsrc[2], 1);
    lit("beq_aluc", cap_aluc[2], 6);
    run(6'b000100, 6'd0, 1'b0, 3);
    lit("beq_not_taken_pcen", int'(cap_pcen[2]), 0);

    run(6'b101011, 6'd0, 1'b0, 4);
    lit("sw_seq", cap_seq, 'h0125);
    lit("sw_memwrite", int'(cap_memw[3:0]), 'b1000);
    run(6'b000010, 6'd0, 1'b0, 3);
    lit("j_seq", cap_seq, 'h01B);
    lit("j_pcen", int'(cap_pcen[2]), 1);
    lit("j_pcsrc", cap_pcsrc[2], 2);
    run(6'b111111, 6'd0, 1'b0, 2);
    lit("illegal_seq", cap_seq, 'h01);
    lit("illegal_writes", int'(cap_regw[1:0] | cap_memw[1:0]), 0);
    run(6'b001000, 6'd0, 1'b0, 4);
    lit("addi_seq", cap_seq, 'h019A);
    lit("addi_regwrite", int'(cap_regw[3:0]), 'b1000);

    run(6'b100011, 6'd0, 1'b0, 3);
    reset = 1'b1;
    @(negedge clk);
    lit("abort_state_in_reset", int'(State), 0);
    lit("abort_regwrite", int'(RegWrite), 0);
    step();
    reset = 1'b0;
    @(negedge clk);
    lit("abort_next_state", int'(State), 0);
    lit("abort_next_regwrite", int'(RegWrite), 0);
    step();

    for (int c = 0; c < 600; c++) begin
      reset = ($urandom_range(0, 49) == 0);
      Zero = 1'($urandom);
      if (exp_state == 0) begin
        Op = op_tab[$urandom_range(0, 6)];
        Funct = fn_tab[$urandom_range(0, 5)];
      end
      step();
    end
    reset = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
